score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 WIN_SCORE, 9, point value (1..9) that ends the game.
REQ-002 HOLD_FRAMES, 60, frames the ball stays frozen after a goal (1..255).
REQ-003 PLAYER_X / ENEMY_X / SCORE_Y, 200 / 420 / 16, constant digit positions driven onto x_pos/y_pos.
REQ-004 clk_i  input  1  pixel clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 frame_tick_i  input  1  one-cycle pulse at the start of each frame's vertical blank.
REQ-007 player_goal_i / enemy_goal_i  input  1 each  one-cycle pulse, the named side scored.
REQ-008 restart_i  input  1  one-cycle pulse, start a new game.
REQ-009 score_o  score_if.keeper_mp  -  drives player and enemy score_t (x_pos, y_pos, score_val SCORE_H x SCORE_W bitmap).
REQ-010 ball_freeze_o  output  1  high while the ball must not move.
REQ-011 game_over_o / winner_o  output  1 each  game ended; winner (1 = player, 0 = enemy).

Function
REQ-012 SHALL keep two 4-bit counters, player_cnt and enemy_cnt, range 0..WIN_SCORE; no wrap, no overflow.
REQ-013 FSM states SHALL be PLAY, HOLD, OVER; reset state is HOLD with hold_cnt = HOLD_FRAMES.
REQ-014 PLAY + goal pulse: counter increments next cycle; new value == WIN_SCORE -> OVER, else -> HOLD with hold_cnt = HOLD_FRAMES.
REQ-015 Both goal pulses in the same PLAY cycle: player_goal_i SHALL take priority; enemy_goal_i is discarded.
REQ-016 Goal pulses in HOLD or OVER SHALL be ignored.
REQ-017 HOLD: hold_cnt decrements on each frame_tick_i; a tick with hold_cnt == 1 -> PLAY next cycle.
REQ-018 OVER SHALL be held until restart_i; game_over_o = 1 and winner_o registered on entry.
REQ-019 restart_i in any state SHALL clear both counters, game_over_o and winner_o, and enter HOLD with hold_cnt = HOLD_FRAMES.
REQ-020 restart_i SHALL take priority over a coincident goal pulse.
REQ-021 ball_freeze_o SHALL be 1 in HOLD and OVER, 0 in PLAY, registered from the state.
REQ-022 score_val bitmaps SHALL come from an internal 10-glyph font ROM indexed by the counters.
REQ-023 Bitmaps SHALL update only on frame_tick_i (tear-free): glyph sampled on the tick, visible one cycle later.
REQ-024 A counter change with no following tick SHALL leave score_val unchanged.
REQ-025 x_pos/y_pos SHALL be constant from the parameters.

Reset
REQ-026 rst_ni low SHALL asynchronously set counters to 0, hold_cnt = HOLD_FRAMES, state HOLD, ball_freeze_o = 1, game_over_o = 0, winner_o = 0.
REQ-027 While rst_ni is low, both score_val outputs SHALL hold glyph "0".
REQ-028 Reset deassertion mid-game SHALL lose all score; there is no retention.

Configuration
REQ-029 SCORE_BLINK_EN defined: in OVER, the winner's bitmap SHALL be forced to all-zero for alternate 32-frame periods, using a 6-bit frame counter cleared on OVER entry.
REQ-030 SCORE_BLINK_EN undefined: no frame counter is built and the winner's digit is static in OVER.

Verification
REQ-031 Reset release, 60 frame ticks -> ball_freeze_o falls within 1 cycle after the 60th tick; both bitmaps show glyph 0.
REQ-032 PLAY, player_goal_i pulse, no tick -> player_cnt = 1 next cycle; score_val still glyph 0; glyph 1 appears 1 cycle after the next tick; state HOLD.
REQ-033 Both goals in the same PLAY cycle -> player_cnt +1, enemy_cnt unchanged; a goal pulse during HOLD -> no change.
REQ-034 Enemy scores 9 times -> OVER, game_over_o = 1, winner_o = 0; a further goal leaves enemy_cnt = 9.
REQ-035 restart_i coincident with player_goal_i in OVER -> counters 0, game_over_o = 0, HOLD, hold_cnt = 60.
REQ-036 With SCORE_BLINK_EN, in OVER -> the winner's bitmap is zero for 32 ticks then glyph 9 for 32 ticks, repeating; the loser's bitmap is static.

Source files
------------

// File: rtl/score_keeper_if.sv
// Score display bundle: one digit record per side, each carrying a fixed position
// and a SCORE_H x SCORE_W glyph bitmap.
interface score_if;
  localparam int SCORE_H = 5;
  localparam int SCORE_W = 3;

  typedef struct packed {
    logic [9:0]                 x_pos;
    logic [9:0]                 y_pos;
    logic [SCORE_H*SCORE_W-1:0] score_val;
  } score_t;

  score_t player;
  score_t enemy;

  modport keeper_mp (output player, enemy);
  modport view_mp   (input  player, enemy);
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: goal counting, post-goal ball hold, game-over detection and
// tear-free digit bitmaps. Optional winner blink in OVER with SCORE_BLINK_EN.
//
// state | meaning
// PLAY  | ball moving, goal pulses are counted
// HOLD  | ball frozen for HOLD_FRAMES frame ticks after a goal, reset or restart
// OVER  | a side reached WIN_SCORE, waiting for restart
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 60,
  parameter int PLAYER_X    = 200,
  parameter int ENEMY_X     = 420,
  parameter int SCORE_Y     = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_tick_i,
  input  logic        player_goal_i,
  input  logic        enemy_goal_i,
  input  logic        restart_i,
  score_if.keeper_mp  score_o,
  output logic        ball_freeze_o,
  output logic        game_over_o,
  output logic        winner_o
);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;
  typedef logic [14:0] glyph_t;

  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] HOLDV = 8'(HOLD_FRAMES);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [3:0] player_cnt;
  logic [3:0] enemy_cnt;
  glyph_t     player_bmp;
  glyph_t     enemy_bmp;
  logic       blank_player;
  logic       blank_enemy;

  // 3x5 font, row-major, MSB is the top-left pixel
  function automatic glyph_t font(input logic [3:0] d);
    case (d)
      4'd0:    font = 15'b111_101_101_101_111;
      4'd1:    font = 15'b010_110_010_010_111;
      4'd2:    font = 15'b111_001_111_100_111;
      4'd3:    font = 15'b111_001_111_001_111;
      4'd4:    font = 15'b101_101_111_001_001;
      4'd5:    font = 15'b111_100_111_001_111;
      4'd6:    font = 15'b111_100_111_101_111;
      4'd7:    font = 15'b111_001_001_001_001;
      4'd8:    font = 15'b111_101_111_101_111;
      4'd9:    font = 15'b111_101_111_001_111;
      default: font = 15'b000_000_000_000_000;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= HOLD;
      hold_cnt      <= HOLDV;
      player_cnt    <= 4'd0;
      enemy_cnt     <= 4'd0;
      ball_freeze_o <= 1'b1;
      game_over_o   <= 1'b0;
      winner_o      <= 1'b0;
    end else if (restart_i) begin
      state         <= HOLD;
      hold_cnt      <= HOLDV;
      player_cnt    <= 4'd0;
      enemy_cnt     <= 4'd0;
      ball_freeze_o <= 1'b1;
      game_over_o   <= 1'b0;
      winner_o      <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          // player wins a same-cycle tie; the enemy pulse is simply dropped
          if (player_goal_i || enemy_goal_i) begin
            ball_freeze_o <= 1'b1;
            if (player_goal_i) begin
              player_cnt <= player_cnt + 4'd1;
              if (player_cnt + 4'd1 == WIN) begin
                state       <= OVER;
                game_over_o <= 1'b1;
                winner_o    <= 1'b1;
              end else begin
                state    <= HOLD;
                hold_cnt <= HOLDV;
              end
            end else begin
              enemy_cnt <= enemy_cnt + 4'd1;
              if (enemy_cnt + 4'd1 == WIN) begin
                state       <= OVER;
                game_over_o <= 1'b1;
                winner_o    <= 1'b0;
              end else begin
                state    <= HOLD;
                hold_cnt <= HOLDV;
              end
            end
          end
        end
        HOLD: begin
          if (frame_tick_i) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt == 8'd1) begin
              state         <= PLAY;
              ball_freeze_o <= 1'b0;
            end
          end
        end
        OVER: ;
        default: begin
          state         <= HOLD;
          hold_cnt      <= HOLDV;
          ball_freeze_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef SCORE_BLINK_EN
  logic [5:0] blink_cnt;

  // free-running while OVER, held at zero otherwise so each game over starts blanked
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      blink_cnt <= 6'd0;
    else if (state != OVER)
      blink_cnt <= 6'd0;
    else if (frame_tick_i)
      blink_cnt <= blink_cnt + 6'd1;
  end

  assign blank_player = (state == OVER) &&  winner_o && !blink_cnt[5];
  assign blank_enemy  = (state == OVER) && !winner_o && !blink_cnt[5];
`else
  assign blank_player = 1'b0;
  assign blank_enemy  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      player_bmp <= font(4'd0);
      enemy_bmp  <= font(4'd0);
    end else if (frame_tick_i) begin
      player_bmp <= blank_player ? '0 : font(player_cnt);
      enemy_bmp  <= blank_enemy  ? '0 : font(enemy_cnt);
    end
  end

  assign score_o.player = {10'(PLAYER_X), 10'(SCORE_Y), player_bmp};
  assign score_o.enemy  = {10'(ENEMY_X),  10'(SCORE_Y), enemy_bmp};

endmodule
